// File: rtl/cb2_index_search.sv
// rtl/cb2_index_search.sv - nearest-entry search over the 16-entry codebook-2 ROM
//
// Scans ROM addresses 0..15, one per cycle, and reports the address whose
// entry is closest to a latched sign-magnitude target (S-E-M 1-15-16).
// Optional feature macro: CB2_SEARCH_ERR_OUT_EN (adds err_out).
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-low reset
//   start    - search request, sampled only in IDLE
//   target   - value to quantize, sign-magnitude 1-15-16
//   rom_addr - codebook ROM address (0 outside SCAN)
//   rom_data - combinational ROM word for rom_addr, non-negative
//   busy     - high while scanning
//   done     - one-cycle pulse when index (and err_out) are updated
//   index    - nearest ROM address from the last completed search
//   err_out  - best error of the last completed search (macro only)

module cb2_index_search (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] target,
  output logic [3:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  index
`ifdef CB2_SEARCH_ERR_OUT_EN
  ,
  output logic [31:0] err_out
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] target_q;
  logic [31:0] best_err;
  logic [3:0]  best_idx;

  logic [30:0] tmag;
  logic [30:0] rmag;
  logic [31:0] sum;
  logic [31:0] err;
  logic        better;
  logic [31:0] fin_err;
  logic [3:0]  fin_idx;
  logic        last_addr;

  // ROM sign bit is always zero, so it carries no information.
  logic unused_rom_sign;
  assign unused_rom_sign = rom_data[31];

  // Distance between target and the current ROM word.
  always_comb begin
    tmag = target_q[30:0];
    rmag = rom_data[30:0];
    sum  = {1'b0, tmag} + {1'b0, rmag};
    err  = 32'd0;
    if (target_q[31]) begin
      // Negative target: distance is the sum of magnitudes, clamped to 31 bits.
      err = sum[31] ? 32'h7FFF_FFFF : sum;
    end else if (tmag >= rmag) begin
      err = {1'b0, tmag - rmag};
    end else begin
      err = {1'b0, rmag - tmag};
    end
    // Strict compare keeps the lowest address on ties.
    better    = (err < best_err);
    fin_err   = better ? err : best_err;
    fin_idx   = better ? rom_addr : best_idx;
    last_addr = (rom_addr == 4'd15);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (last_addr) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Results are registered on the final SCAN edge (folding in the address-15
  // comparison) so they are already valid during the DONE pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      target_q <= 32'd0;
      rom_addr <= 4'd0;
      best_err <= 32'hFFFF_FFFF;
      best_idx <= 4'd0;
      index    <= 4'd0;
`ifdef CB2_SEARCH_ERR_OUT_EN
      err_out  <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            target_q <= target;
          end
          rom_addr <= 4'd0;
          best_err <= 32'hFFFF_FFFF;
          best_idx <= 4'd0;
        end
        SCAN: begin
          best_err <= fin_err;
          best_idx <= fin_idx;
          if (last_addr) begin
            rom_addr <= 4'd0;
            index    <= fin_idx;
`ifdef CB2_SEARCH_ERR_OUT_EN
            err_out  <= fin_err;
`endif
          end else begin
            rom_addr <= rom_addr + 4'd1;
          end
        end
        default: begin
          rom_addr <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cb2_index_search.sv
// tb/tb_cb2_index_search.sv - self-checking bench for cb2_index_search

module tb_cb2_index_search;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] target = 32'd0;
  logic [3:0]  rom_addr;
  logic [31:0] rom_data;
  logic        busy;
  logic        done;
  logic [3:0]  index;
  logic [31:0] err_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Codebook 2: 500 + 50*addr, integer part in bits 30:16.
  always_comb rom_data = (32'd500 + 32'd50 * {28'd0, rom_addr}) << 16;

  cb2_index_search dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .target   (target),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .done     (done),
    .index    (index)
`ifdef CB2_SEARCH_ERR_OUT_EN
    ,
    .err_out  (err_out)
`endif
  );

  // Reference: signed distance in plain integer arithmetic, clamped to 31 bits.
  function automatic void ref_search(input logic [31:0] t, output logic [3:0] idx,
                                     output logic [31:0] err);
    longint mag, tv, r, e, best;
    mag  = longint'({33'd0, t[30:0]});
    tv   = t[31] ? -mag : mag;
    best = 64'sh7FFF_FFFF_FFFF;
    idx  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      r = longint'(500 + 50 * i) * 65536;
      e = tv - r;
      if (e < 0) e = -e;
      if (e > 64'sh7FFF_FFFF) e = 64'sh7FFF_FFFF;
      if (e < best) begin
        best = e;
        idx  = 4'(i);
      end
    end
    err = 32'(best);
  endfunction

  // Pulses start for one cycle and returns the cycle of done (-1 on timeout).
  task automatic do_search(input logic [31:0] t, output int lat, output logic [3:0] idx,
                           output logic [31:0] eo, output logic [63:0] addrs);
    @(posedge clk); #1;
    target = t;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    target = $urandom();
    lat   = -1;
    idx   = 4'd0;
    eo    = 32'd0;
    addrs = 64'd0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 16) addrs[(k-1)*4 +: 4] = rom_addr;
      if (done) begin
        lat = k;
        idx = index;
        eo  = err_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    start  = 1'b1;
    target = 32'h03E8_0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, index, rom_addr} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b index=%0d rom_addr=%0d exp all 0",
               busy, done, index, rom_addr);
    end
`ifdef CB2_SEARCH_ERR_OUT_EN
    checks++;
    if (err_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_err_out got=%h exp=00000000", err_out);
    end
`endif
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_directed();
    logic [31:0] tv [8];
    logic [3:0]  ix [8];
    logic [31:0] ev [8];
    logic [63:0] aexp;
    int lat;
    logic [3:0]  idx;
    logic [31:0] eo;
    logic [63:0] addrs;
    tv = '{32'h01F4_0000, 32'h03E8_0000, 32'h07D0_0000, 32'h020D_0000,
           32'h8064_0000, 32'hFFFF_FFFF, 32'h0400_0000, 32'h0000_0000};
    ix = '{4'd0, 4'd10, 4'd15, 4'd0, 4'd0, 4'd0, 4'd10, 4'd0};
    ev = '{32'h0000_0000, 32'h0000_0000, 32'h02EE_0000, 32'h0019_0000,
           32'h0258_0000, 32'h7FFF_FFFF, 32'h0018_0000, 32'h01F4_0000};
    for (int i = 0; i < 16; i++) aexp[i*4 +: 4] = 4'(i);
    for (int n = 0; n < 8; n++) begin
      do_search(tv[n], lat, idx, eo, addrs);
      checks++;
      if (lat !== 17) begin
        failures++;
        $display("FAIL directed_latency t=%h got=%0d exp=17", tv[n], lat);
      end
      checks++;
      if (idx !== ix[n]) begin
        failures++;
        $display("FAIL directed_index t=%h got=%0d exp=%0d", tv[n], idx, ix[n]);
      end
      checks++;
      if (addrs !== aexp) begin
        failures++;
        $display("FAIL directed_addr_seq t=%h got=%h exp=%h", tv[n], addrs, aexp);
      end
`ifdef CB2_SEARCH_ERR_OUT_EN
      checks++;
      if (eo !== ev[n]) begin
        failures++;
        $display("FAIL directed_err_out t=%h got=%h exp=%h", tv[n], eo, ev[n]);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    logic [3:0]  eidx, idx;
    logic [31:0] eerr, eo;
    logic [63:0] addrs;
    int lat;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: t = {1'b0, 15'($urandom_range(400, 1400)), 16'($urandom())};
        1: t = {1'b1, 15'($urandom_range(0, 300)), 16'($urandom())};
        2: t = {1'b0, 15'(525 + 50 * $urandom_range(0, 13)), 16'h0000};
        default: t = $urandom();
      endcase
      ref_search(t, eidx, eerr);
      do_search(t, lat, idx, eo, addrs);
      checks++;
      if (lat !== 17 || idx !== eidx) begin
        failures++;
        $display("FAIL random_index t=%h got idx=%0d lat=%0d exp idx=%0d lat=17",
                 t, idx, lat, eidx);
      end
`ifdef CB2_SEARCH_ERR_OUT_EN
      checks++;
      if (eo !== eerr) begin
        failures++;
        $display("FAIL random_err_out t=%h got=%h exp=%h", t, eo, eerr);
      end
`endif
    end
  endtask

  task automatic test_ignore();
    int ndone, first;
    logic [3:0] idx17;
    ndone = 0;
    first = -1;
    idx17 = 4'd0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c > 0 && done) begin
        ndone++;
        if (first < 0) begin
          first = c;
          idx17 = index;
        end
      end
      case (c)
        0:  begin start = 1'b1; target = 32'h03E8_0000; end
        1:  begin start = 1'b0; target = 32'h07D0_0000; end
        5:  start = 1'b1;
        6:  start = 1'b0;
        17: start = 1'b1;
        18: start = 1'b0;
        default: ;
      endcase
    end
    checks++;
    if (ndone !== 1 || first !== 17) begin
      failures++;
      $display("FAIL ignore_start got done_count=%0d first=%0d exp 1 at 17", ndone, first);
    end
    checks++;
    if (idx17 !== 4'd10) begin
      failures++;
      $display("FAIL ignore_target got=%0d exp=10", idx17);
    end
    checks++;
    if (index !== 4'd10) begin
      failures++;
      $display("FAIL index_hold got=%0d exp=10", index);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [3:0]  idx;
    logic [31:0] eo;
    logic [63:0] addrs;
    logic saw_done;
    do_search(32'h03E8_0000, lat, idx, eo, addrs);
    checks++;
    if (idx !== 4'd10) begin
      failures++;
      $display("FAIL abort_pre_index got=%0d exp=10", idx);
    end
    saw_done = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (c > 0 && done) saw_done = 1'b1;
      case (c)
        0: begin start = 1'b1; target = 32'h03E8_0000; end
        1: start = 1'b0;
        5: begin start = 1'b1; target = 32'h07D0_0000; end
        6: start = 1'b0;
        7: begin
          checks++;
          if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before got=%b exp=1", busy);
          end
        end
        8: rst = 1'b0;
        9: begin
          rst = 1'b1;
          checks++;
          if (busy !== 1'b0 || index !== 4'd0 || rom_addr !== 4'd0) begin
            failures++;
            $display("FAIL abort_state got busy=%b index=%0d rom_addr=%0d exp 0 0 0",
                     busy, index, rom_addr);
          end
        end
        default: ;
      endcase
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done got=%b exp=0", saw_done);
    end
    do_search(32'h07D0_0000, lat, idx, eo, addrs);
    checks++;
    if (lat !== 17 || idx !== 4'd15) begin
      failures++;
      $display("FAIL abort_recover got idx=%0d lat=%0d exp idx=15 lat=17", idx, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] busy_got, busy_exp, done_got, done_exp;
    logic [3:0]  eidx;
    logic [31:0] eerr;
    int bad_idx;
    ref_search(32'h04B0_0000, eidx, eerr);
    bad_idx = 0;
    @(negedge clk);
    start  = 1'b1;
    target = 32'h04B0_0000;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 40) start = 1'b0;
      busy_got[k-1] = busy;
      done_got[k-1] = done;
      busy_exp[k-1] = ((k - 1) % 18) < 16;
      done_exp[k-1] = ((k - 1) % 18) == 16;
      if (done && index !== eidx) bad_idx++;
    end
    checks++;
    if (done_got !== done_exp) begin
      failures++;
      $display("FAIL b2b_done got=%h exp=%h", done_got, done_exp);
    end
    checks++;
    if (busy_got !== busy_exp) begin
      failures++;
      $display("FAIL b2b_busy got=%h exp=%h", busy_got, busy_exp);
    end
    checks++;
    if (bad_idx !== 0 || eidx !== 4'd14) begin
      failures++;
      $display("FAIL b2b_index got bad=%0d ref=%0d exp bad=0 ref=14", bad_idx, eidx);
    end
    repeat (25) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cb2_index_search.md
CB2_INDEX_SEARCH -- requirements
Module: cb2_index_search

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: request a codebook search; sampled only in IDLE.
REQ-004 SHALL have port target, input, 32 bits: value to quantize, sign-magnitude fixed point S-E-M 1-15-16 (bit31 sign, bits30:16 integer, bits15:0 fraction).
REQ-005 SHALL have port rom_addr, output, 4 bits: address driven to the 16-entry codebook-2 ROM (500..1250 in steps of 50, same format).
REQ-006 SHALL have port rom_data, input, 32 bits: combinational ROM output for rom_addr, same format, always non-negative.
REQ-007 SHALL have port busy, output, 1 bit: high while in SCAN.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse when index is updated.
REQ-009 SHALL have port index, output, 4 bits: nearest codebook address from the last completed search.

Function
REQ-010 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-011 IDLE: start=1 at edge T SHALL latch target, set rom_addr=0, best_err=all-ones, best_idx=0, and enter SCAN at T+1.
REQ-012 SCAN: each cycle SHALL compute err = |target - rom_data| as 32-bit unsigned magnitude, bits 30:0 significant.
- target sign=0: err = |tmag - rom_data[30:0]|.
- target sign=1: err = tmag + rom_data[30:0], saturating at 0x7FFFFFFF.
REQ-013 SHALL update best_err/best_idx only when err < best_err strictly, so the lowest index wins ties.
REQ-014 SHALL increment rom_addr by 1 per SCAN cycle; after evaluating address 15 it SHALL enter DONE without wrapping into a 17th evaluation.
REQ-015 DONE: SHALL load index from best_idx, assert done for exactly one cycle, then return to IDLE.
REQ-016 Latency: start sampled at edge T gives done=1 during cycle T+17; addresses 0..15 are presented during T+1..T+16.
REQ-017 start while busy or in DONE SHALL be ignored; the target input is not re-sampled mid-search.
REQ-018 index SHALL hold its value from DONE until the next DONE.
REQ-019 Back-to-back: start held high SHALL begin a new search in the IDLE cycle after DONE, giving an 18-cycle period.
REQ-020 rom_addr SHALL be 0 in IDLE and DONE.

Reset
REQ-021 rst=0 at a clock edge SHALL force IDLE, rom_addr=0, busy=0, done=0, index=0, best_err=all-ones, best_idx=0 (and err_out=0 when compiled in).
REQ-022 Reset mid-SCAN SHALL abort the search with no done pulse, and index SHALL read 0.
REQ-023 Reset SHALL take priority over start at the same edge.

Configuration
REQ-024 Macro CB2_SEARCH_ERR_OUT_EN defined: SHALL add output port err_out, 32 bits, loaded with best_err in DONE together with index and held until the next DONE.
REQ-025 Macro undefined: err_out SHALL not exist; all other behaviour and timing SHALL be unchanged.

Verification
REQ-026 target=0x01F40000 (500.0), start pulse -> done at T+17, index=0, err_out=0x00000000.
REQ-027 target=0x03E80000 (1000.0) -> index=10; target=0x07D00000 (2000.0) -> index=15, err_out=0x02EE0000 (750.0).
REQ-028 target=0x020D0000 (525.0), equidistant from 500 and 550 -> index=0 (tie rule).
REQ-029 target=0x80640000 (-100.0) -> index=0, err_out=0x02580000 (600.0).
REQ-030 Start 1000.0, second start at T+5 with target 2000.0, rst=0 at T+8 -> no done pulse, busy=0 at T+9, index=0; new start -> normal result.
REQ-031 start held high for 40 cycles, target=0x04B00000 (1200.0) -> done pulses at T+17 and T+35, index=14 both times, busy low exactly in the IDLE and DONE cycles.
